// File: rtl/serial_cmp.sv
// Bit-serial MSB-first magnitude comparator with signed/unsigned mode and registered lt/eq/gt flags.
// Optional build macro SERIAL_CMP_EARLY_EXIT_EN finishes the scan on the first differing bit.
module serial_cmp #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic             a_gt_b
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             mode_r;
    logic [IW-1:0]    idx_r;
    logic             decided_r;
    logic             lt_r;
    logic             diff_s;
    logic             first_diff_s;
    logic             lt_bit_s;
    logic             decided_now_s;
    logic             lt_now_s;
    logic             load_flags_s;

    // Decision logic for the bit pair under the scan index
    always_comb begin
        diff_s        = a_r[idx_r] ^ b_r[idx_r];
        first_diff_s  = diff_s & ~decided_r;
        // A set sign bit marks the more negative operand; any other set bit marks the larger one.
        if (mode_r && (idx_r == MSB_IDX)) begin
            lt_bit_s = a_r[idx_r];
        end else begin
            lt_bit_s = ~a_r[idx_r];
        end
        decided_now_s = decided_r | diff_s;
        if (decided_r) begin
            lt_now_s = lt_r;
        end else begin
            lt_now_s = diff_s & lt_bit_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        load_flags_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SCAN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SCAN: begin
                if (idx_r == {IW{1'b0}}) begin
                    state_next_s = DONE;
                end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                else if (first_diff_s) begin
                    state_next_s = DONE;
                end
`endif
                else begin
                    state_next_s = SCAN;
                end
                load_flags_s = (state_next_s == DONE);
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand latch and running decision
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            mode_r    <= 1'b0;
            idx_r     <= {IW{1'b0}};
            decided_r <= 1'b0;
            lt_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r       <= a;
                        b_r       <= b;
                        mode_r    <= signed_mode;
                        idx_r     <= MSB_IDX;
                        decided_r <= 1'b0;
                        lt_r      <= 1'b0;
                    end
                end
                SCAN: begin
                    decided_r <= decided_now_s;
                    lt_r      <= lt_now_s;
                    if (idx_r != {IW{1'b0}}) begin
                        idx_r <= idx_r - IW'(1);
                    end
                end
                default: begin
                    decided_r <= decided_r;
                end
            endcase
        end
    end

    // Registered status and result flags; flags load only when entering DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            a_lt_b <= 1'b0;
            a_eq_b <= 1'b0;
            a_gt_b <= 1'b0;
        end else begin
            busy <= (state_next_s != IDLE);
            done <= load_flags_s;
            if (load_flags_s) begin
                a_lt_b <= decided_now_s & lt_now_s;
                a_eq_b <= ~decided_now_s;
                a_gt_b <= decided_now_s & ~lt_now_s;
            end
        end
    end

endmodule

// File: doc/serial_cmp.md
# serial_cmp

Parametrised bit-serial magnitude comparator, the multi-cycle successor to the team's fixed 6-bit combinational signed less-than block. It latches two WIDTH-bit operands on a start pulse and scans them MSB-first, one bit pair per clock. It reports registered less-than, equal and greater-than flags with a done pulse. A per-operation mode input selects two's-complement or unsigned comparison, so one instance serves both the datapath compare and the address/counter compare uses.

## Interface
- WIDTH, 6, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with the operands.
- a  input  WIDTH  operand A; latched on an accepted start.
- b  input  WIDTH  operand B; latched on an accepted start.
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle completion pulse.
- a_lt_b  output  1  registered A < B.
- a_eq_b  output  1  registered A == B.
- a_gt_b  output  1  registered A > B.

## Operation
- FSM states: IDLE, SCAN, DONE. Reset state is IDLE.
- IDLE, start=1: latch a, b and signed_mode; set the bit index to WIDTH-1; clear the internal decision (undecided); go to SCAN.
- SCAN: one bit pair per cycle, index counting down.
  - First differing bit at the MSB, signed_mode=1: the operand with a 1 is smaller (negative).
  - First differing bit anywhere else, or in unsigned mode: the operand with a 1 is larger.
  - After the first difference is found, later bits do not alter the decision.
- SCAN at index 0: the next state is DONE. Result flags load at that edge. If no difference was found, a_eq_b=1.
- DONE lasts exactly one cycle, then returns to IDLE.
- start in SCAN or DONE is ignored. Inputs a, b and signed_mode are don't-care outside the accepting IDLE cycle.
- Result flags are one-hot after the first completion. They hold their value until the next operation's DONE entry, including while busy.
- Reset values: all outputs 0, including all three result flags, until the first completion.

## Timing
- Start accepted at clock edge E0.
- Without early exit: done=1 in the cycle following edge E0+WIDTH. Start-to-done latency is WIDTH cycles; the next start can be accepted WIDTH+2 cycles after E0.
- Flags change only on the edge on which done rises.
- busy rises after E0 and falls after the DONE cycle.
- rst=1 at any edge, including mid-SCAN or during DONE:
  - Next state is IDLE; all outputs are 0 the following cycle.
  - The in-flight operation is discarded with no done pulse.
  - start asserted together with rst is ignored.
- WIDTH=2 is legal; the MSB rule and bit 0 are the only bits scanned.

## Configuration
- SERIAL_CMP_EARLY_EXIT_EN defined: SCAN goes to DONE on the edge that processes the first differing bit. A first difference at index i gives done after edge E0+(WIDTH-i). Equal operands still take the full WIDTH cycles.
- Undefined: the scan always covers all WIDTH bits; latency is a fixed WIDTH cycles regardless of data.
- Flag values are identical in both builds; only latency differs.

## Test plan
All cases use WIDTH=6.
- Signed, a=6'b111101 (-3), b=6'b000010 (+2) -> a_lt_b=1, eq=0, gt=0; done after edge E0+6 (macro off) or E0+1 (macro on).
- Unsigned, same operands -> a_gt_b=1; done after E0+6 (off) or E0+1 (on).
- a=b=6'b101010, both modes -> a_eq_b=1; done after E0+6 with the macro both on and off.
- Unsigned, a=6'b000100, b=6'b000101 -> a_lt_b=1; done after E0+6 in both builds, since the first difference is at bit 0.
- start pulsed at E0+2 with new operands during busy -> ignored; the result reflects the E0 operands; a single done pulse.
- rst asserted at E0+3 mid-SCAN -> no done; busy=0 and all flags 0 from the next cycle. A fresh start then completes normally.
